smart_mac_seq_ctrl: RTL and testbench

Sequencer for one row of NUM_PE smart MAC units that share a horizontal and a vertical smart bypass bus.

---
 rtl/smart_mac_seq_ctrl_pkg.sv | 34 +++
 rtl/smart_mac_seq_ctrl_if.sv | 34 +++
 rtl/smart_mac_seq_ctrl_onehot_dec.sv | 23 ++
 rtl/smart_mac_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_smart_mac_seq_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/smart_mac_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smart_mac_ctrl_pkg
// Brief    : State encoding and one-hot decode helper for the smart MAC
//            row sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package smart_mac_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] c_ST_LOAD    = 3'd1;
    localparam logic [STATE_W-1:0] c_ST_COMPUTE = 3'd2;
    localparam logic [STATE_W-1:0] c_ST_DRAIN   = 3'd3;
    localparam logic [STATE_W-1:0] c_ST_DONE    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_LOAD    = c_ST_LOAD,
        ST_COMPUTE = c_ST_COMPUTE,
        ST_DRAIN   = c_ST_DRAIN,
        ST_DONE    = c_ST_DONE
    } state_t;

    // One bit of an enabled one-hot decode: set only at the selected position.
    function automatic logic onehot_bit(input int unsigned idx,
                                        input int unsigned pos,
                                        input logic        en);
        return en && (idx == pos);
    endfunction

endpackage
`default_nettype wire

// File: rtl/smart_mac_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : smart_mac_seq_ctrl_if
// Brief    : MAC-row control lines, smart-bus selects and drain handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface smart_mac_seq_ctrl_if #(
    parameter int NUM_PE    = 4,
    parameter int IDX_WIDTH = $clog2(NUM_PE)
);
    logic                 stat_bit_out;
    logic                 fsm_op2_select_out;
    logic                 fsm_out_select_out;
    logic [NUM_PE-1:0]    select_right_out_smart_out;
    logic [NUM_PE-1:0]    select_bottom_out_smart_out;
    logic                 drain_valid_out;
    logic [IDX_WIDTH-1:0] drain_idx_out;
    logic                 drain_ready_in;

    modport master (
        output stat_bit_out, fsm_op2_select_out, fsm_out_select_out,
               select_right_out_smart_out, select_bottom_out_smart_out,
               drain_valid_out, drain_idx_out,
        input  drain_ready_in
    );

    modport slave (
        input  stat_bit_out, fsm_op2_select_out, fsm_out_select_out,
               select_right_out_smart_out, select_bottom_out_smart_out,
               drain_valid_out, drain_idx_out,
        output drain_ready_in
    );
endinterface
`default_nettype wire

// File: rtl/smart_mac_seq_ctrl_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : smart_bus_onehot_dec
// Brief    : Index to NUM_PE-wide one-hot select; all zeros when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module smart_bus_onehot_dec
    import smart_mac_ctrl_pkg::*;
#(
    parameter int NUM_PE    = 4,
    parameter int IDX_WIDTH = $clog2(NUM_PE)
) (
    input  wire logic [IDX_WIDTH-1:0] i_idx,
    input  wire logic                 i_en,
    output logic      [NUM_PE-1:0]    o_onehot
);

    for (genvar i = 0; i < NUM_PE; i++) begin : g_bit
        assign o_onehot[i] = onehot_bit(int'(i_idx), i, i_en);
    end

endmodule
`default_nettype wire

// File: rtl/smart_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smart_mac_seq_ctrl
// Brief    : Load / accumulate / drain sequencer for one row of smart MACs.
// Revision : 1.0 - initial release
// ============================================================================
module smart_mac_seq_ctrl
    import smart_mac_ctrl_pkg::*;
#(
    parameter int NUM_PE    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int IDX_WIDTH = $clog2(NUM_PE)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start_in,
    input  wire logic [CNT_WIDTH-1:0] k_len_in,
    input  wire logic                 abort_in,
    output logic                      busy_out,
    output logic                      done_out,
    smart_mac_seq_ctrl_if.master      mac_if
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_PE = IDX_WIDTH'(NUM_PE - 1);

    state_t               r_state,    w_state_nxt;
    logic [IDX_WIDTH-1:0] r_pe_cnt,   w_pe_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_k_cnt,    w_k_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_k_len,    w_k_len_nxt;

    logic                 r_busy, r_done, r_stat, r_op2, r_out_sel, r_drain_valid;
    logic [IDX_WIDTH-1:0] r_drain_idx;
    logic [NUM_PE-1:0]    r_sel_right, r_sel_bottom;

    logic                 w_drain_nxt;
    logic [NUM_PE-1:0]    w_sel_right, w_sel_bottom;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pe_cnt <= '0;
            r_k_cnt  <= '0;
            r_k_len  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pe_cnt <= w_pe_cnt_nxt;
            r_k_cnt  <= w_k_cnt_nxt;
            r_k_len  <= w_k_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pe_cnt_nxt = r_pe_cnt;
        w_k_cnt_nxt  = r_k_cnt;
        w_k_len_nxt  = r_k_len;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    if (k_len_in != '0) begin
                        w_state_nxt  = ST_LOAD;
                        w_k_len_nxt  = k_len_in;
                        w_pe_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (r_pe_cnt == c_LAST_PE) begin
                    w_state_nxt = ST_COMPUTE;
                    w_k_cnt_nxt = '0;
                end else begin
                    w_pe_cnt_nxt = r_pe_cnt + 1'b1;
                end
            end
            ST_COMPUTE: begin
                // Compare against K-1 so K = 2^CNT_WIDTH-1 finishes before any wrap.
                if (r_k_cnt == r_k_len - 1'b1) begin
                    w_state_nxt  = ST_DRAIN;
                    w_pe_cnt_nxt = '0;
                end else begin
                    w_k_cnt_nxt = r_k_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_valid && mac_if.drain_ready_in) begin
                    if (r_pe_cnt == c_LAST_PE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_pe_cnt_nxt = r_pe_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort_in) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_drain_nxt = (w_state_nxt == ST_DRAIN);

    smart_bus_onehot_dec #(
        .NUM_PE    (NUM_PE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_dec_right (
        .i_idx    (w_pe_cnt_nxt),
        .i_en     (w_drain_nxt),
        .o_onehot (w_sel_right)
    );

    smart_bus_onehot_dec #(
        .NUM_PE    (NUM_PE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_dec_bottom (
        .i_idx    (w_pe_cnt_nxt),
        .i_en     (w_drain_nxt),
        .o_onehot (w_sel_bottom)
    );

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stat        <= 1'b0;
            r_op2         <= 1'b0;
            r_out_sel     <= 1'b0;
            r_drain_valid <= 1'b0;
            r_drain_idx   <= '0;
            r_sel_right   <= '0;
            r_sel_bottom  <= '0;
        end else begin
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_DONE);
            r_stat        <= (w_state_nxt == ST_LOAD);
            r_op2         <= (w_state_nxt == ST_COMPUTE) && (w_k_cnt_nxt != '0);
            r_out_sel     <= w_drain_nxt;
            r_drain_valid <= w_drain_nxt;
            r_drain_idx   <= w_drain_nxt ? w_pe_cnt_nxt : '0;
            r_sel_right   <= w_sel_right;
            r_sel_bottom  <= w_sel_bottom;
        end
    end

    assign busy_out                           = r_busy;
    assign done_out                           = r_done;
    assign mac_if.stat_bit_out                = r_stat;
    assign mac_if.fsm_op2_select_out          = r_op2;
    assign mac_if.fsm_out_select_out          = r_out_sel;
    assign mac_if.drain_valid_out             = r_drain_valid;
    assign mac_if.drain_idx_out               = r_drain_idx;
    assign mac_if.select_right_out_smart_out  = r_sel_right;
    assign mac_if.select_bottom_out_smart_out = r_sel_bottom;

endmodule
`default_nettype wire

// File: tb/tb_smart_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_smart_mac_seq_ctrl
// Brief    : Directed self-checking bench with a drain-beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smart_mac_seq_ctrl;

    localparam int NUM_PE    = 4;
    localparam int CNT_WIDTH = 8;
    localparam int IDX_WIDTH = 2;
    localparam int MAX_WAIT  = 2000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_in;
    logic [CNT_WIDTH-1:0] k_len_in;
    logic                 abort_in;
    logic                 busy_out;
    logic                 done_out;

    smart_mac_seq_ctrl_if #(.NUM_PE(NUM_PE), .IDX_WIDTH(IDX_WIDTH)) mac_if ();

    smart_mac_seq_ctrl #(
        .NUM_PE    (NUM_PE),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_in (start_in),
        .k_len_in (k_len_in),
        .abort_in (abort_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .mac_if   (mac_if)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc, done_cyc;
    int   stat_cnt, out_sel_cnt, done_cnt;
    logic any_ctrl;
    logic op2_log[$];
    int   exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {busy_out, done_out, mac_if.stat_bit_out, mac_if.fsm_op2_select_out,
                mac_if.fsm_out_select_out, mac_if.drain_valid_out, mac_if.drain_idx_out,
                mac_if.select_right_out_smart_out, mac_if.select_bottom_out_smart_out};
    endfunction

    task automatic clear_stats();
        stat_cnt = 0; out_sel_cnt = 0; done_cnt = 0; done_cyc = -1;
        any_ctrl = 1'b0;
        op2_log.delete();
    endtask

    // Samples the settled outputs of the current cycle, then advances one clock.
    task automatic tick();
        int e;
        if (mac_if.drain_valid_out && mac_if.drain_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("drain_idx", 32'(mac_if.drain_idx_out), 32'(e));
                chk("sel_right", 32'(mac_if.select_right_out_smart_out), 32'(1) << e);
                chk("sel_bottom", 32'(mac_if.select_bottom_out_smart_out), 32'(1) << e);
            end
        end
        if (mac_if.stat_bit_out)       stat_cnt++;
        if (mac_if.fsm_out_select_out) out_sel_cnt++;
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_out && !mac_if.stat_bit_out && !mac_if.fsm_out_select_out && !done_out)
            op2_log.push_back(mac_if.fsm_op2_select_out);
        if (mac_if.stat_bit_out || mac_if.fsm_op2_select_out || mac_if.fsm_out_select_out ||
            (mac_if.select_right_out_smart_out != '0) || (mac_if.select_bottom_out_smart_out != '0))
            any_ctrl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_tile(input int k);
        clear_stats();
        k_len_in = CNT_WIDTH'(k);
        start_in = 1'b1;
        if (k != 0) for (int i = 0; i < NUM_PE; i++) exp_q.push_back(i);
        start_cyc = cyc;
        tick();
        start_in = 1'b0;
    endtask

    // Runs until the done pulse, optionally stalling bp_len cycles when index bp_idx is on the bus.
    task automatic run_to_done(input int bp_idx, input int bp_len);
        int bp_left = bp_len;
        int n = 0;
        while (done_cnt == 0 && n < MAX_WAIT) begin
            if (mac_if.drain_valid_out && int'(mac_if.drain_idx_out) == bp_idx && bp_left > 0) begin
                mac_if.drain_ready_in = 1'b0;
                bp_left--;
                chk("bp_hold_sel", 32'(mac_if.select_right_out_smart_out), 32'(1) << bp_idx);
                chk("bp_hold_valid", 32'(mac_if.drain_valid_out), 32'd1);
            end else begin
                mac_if.drain_ready_in = 1'b1;
            end
            tick();
            n++;
        end
        mac_if.drain_ready_in = 1'b1;
        if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
        chk("done_width", 32'(done_out), 32'd0);
        chk("idle_after_done", 32'(busy_out), 32'd0);
    endtask

    task automatic check_tile(input string tag, input int k, input int lat);
        chk({tag, "_latency"}, 32'(done_cyc - start_cyc + 1), 32'(lat));
        chk({tag, "_stat_cycles"}, 32'(stat_cnt), 32'(NUM_PE));
        chk({tag, "_compute_cycles"}, 32'(op2_log.size()), 32'(k));
        for (int i = 0; i < op2_log.size(); i++)
            chk({tag, "_op2"}, 32'(op2_log[i]), (i == 0) ? 32'd0 : 32'd1);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start_in = 1'b0; k_len_in = '0; abort_in = 1'b0;
        mac_if.drain_ready_in = 1'b1;
        clear_stats();
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'(busy_out), 32'd0);

        // Asynchronous reset in the middle of a drain.
        start_tile(3);
        n = 0;
        while (!(mac_if.drain_valid_out && mac_if.drain_idx_out == 2'd1) && n < 50) begin
            tick(); n++;
        end
        chk("reached_drain", 32'(mac_if.drain_valid_out), 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        tick();
        chk("idle_after_async_reset", all_outs(), 32'd0);

        // Nominal tile, K=3.
        start_tile(3);
        run_to_done(-1, 0);
        check_tile("k3", 3, 13);
        chk("k3_out_sel_cycles", 32'(out_sel_cnt), 32'(NUM_PE));

        // Single accumulate cycle.
        start_tile(1);
        run_to_done(-1, 0);
        check_tile("k1", 1, 11);

        // Backpressure at drain index 2.
        start_tile(3);
        run_to_done(2, 3);
        check_tile("bp", 3, 16);
        chk("bp_out_sel_cycles", 32'(out_sel_cnt), 32'(NUM_PE + 3));

        // Zero-length tile goes straight to DONE.
        start_tile(0);
        run_to_done(-1, 0);
        chk("k0_latency", 32'(done_cyc - start_cyc + 1), 32'd2);
        chk("k0_no_ctrl", 32'(any_ctrl), 32'd0);
        chk("k0_done_pulses", 32'(done_cnt), 32'd1);

        // Longest K must not wrap the counter.
        start_tile(255);
        run_to_done(-1, 0);
        check_tile("k255", 255, 265);

        // Start while busy is ignored, then abort in compute cycle 2.
        start_tile(5);
        k_len_in = 8'd1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n = 0;
        while (op2_log.size() < 1 && n < 50) begin
            tick(); n++;
        end
        chk("abort_in_compute", 32'({mac_if.fsm_op2_select_out, mac_if.fsm_out_select_out}), 32'b10);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_outputs", all_outs(), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_stays_idle", 32'(busy_out), 32'd0);

        start_tile(2);
        run_to_done(-1, 0);
        check_tile("after_abort", 2, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
